// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode numbering, control-bit positions, datapath
// widths and the opcode-to-control decode used by the dispatcher.
package alu_pkg;

  localparam int ALU_CTRL_W = 13;
  localparam int DATA_W     = 16;
  localparam int IMM_W      = 5;
  localparam int OPC_W      = 4;

  typedef enum logic [OPC_W-1:0] {
    OP_ADD = 4'd0,
    OP_LD  = 4'd1,
    OP_ST  = 4'd2,
    OP_SUB = 4'd3,
    OP_MUL = 4'd4,
    OP_CMP = 4'd5,
    OP_MOV = 4'd6,
    OP_OR  = 4'd7,
    OP_AND = 4'd8,
    OP_NOT = 4'd9,
    OP_LSL = 4'd10,
    OP_LSR = 4'd11,
    OP_ASR = 4'd12
  } alu_opcode_e;

  localparam int SIG_ADD = 0;
  localparam int SIG_LD  = 1;
  localparam int SIG_ST  = 2;
  localparam int SIG_SUB = 3;
  localparam int SIG_MUL = 4;
  localparam int SIG_CMP = 5;
  localparam int SIG_MOV = 6;
  localparam int SIG_OR  = 7;
  localparam int SIG_AND = 8;
  localparam int SIG_NOT = 9;
  localparam int SIG_LSL = 10;
  localparam int SIG_LSR = 11;
  localparam int SIG_ASR = 12;

  typedef struct packed {
    logic                  illegal;
    logic [ALU_CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0]     op1;
    logic [DATA_W-1:0]     op2;
    logic [IMM_W-1:0]      immx;
    logic                  isimm;
  } alu_op_t;

  // Opcodes past OP_ASR have no control bit; they travel with ctrl=0 and
  // the illegal flag so the result slot is still produced in order.
  function automatic alu_op_t decode_op(
    input logic [OPC_W-1:0]  opcode,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b,
    input logic [IMM_W-1:0]  imm,
    input logic              use_imm
  );
    alu_op_t op;
    op.illegal = (opcode > OP_ASR);
    op.ctrl    = op.illegal ? '0 : (ALU_CTRL_W'(1) << opcode);
    op.op1     = a;
    op.op2     = b;
    op.immx    = imm;
    op.isimm   = use_imm;
    return op;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers for full/empty detection and a
// combinational read of the head entry.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_count = r_wr_ptr - r_rd_ptr;
  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  // NOTE: the storage array is deliberately not reset; occupancy lives only
  // in the pointers, so stale words are never presented as valid entries.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/alu_dispatch.sv
// Dispatches decoded ops to the clocked ALU and collects tagged results,
// with credit flow control so every issued op has a guaranteed result slot.
module alu_dispatch
  import alu_pkg::*;
#(
  parameter int IQ_DEPTH = 4,
  parameter int RQ_DEPTH = 4,
  parameter int TAG_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [OPC_W-1:0]      in_opcode,
  input  logic [DATA_W-1:0]     in_op1,
  input  logic [DATA_W-1:0]     in_op2,
  input  logic [IMM_W-1:0]      in_immx,
  input  logic                  in_isimm,
  input  logic [TAG_W-1:0]      in_tag,
  output logic [ALU_CTRL_W-1:0] alusignals,
  output logic [DATA_W-1:0]     op1,
  output logic [DATA_W-1:0]     op2,
  output logic [IMM_W-1:0]      immx,
  output logic                  isimmediate,
  input  logic [DATA_W-1:0]     aluresult,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_W-1:0]     res_data,
  output logic [TAG_W-1:0]      res_tag,
  output logic                  res_illegal
);

  localparam int IQ_W  = $bits(alu_op_t) + TAG_W;
  localparam int RQ_W  = 1 + DATA_W + TAG_W;
  localparam int IQ_CW = $clog2(IQ_DEPTH) + 1;
  localparam int RQ_CW = $clog2(RQ_DEPTH) + 1;

  logic              w_clr;

  alu_op_t           w_in_op;
  alu_op_t           w_iq_op;
  logic [TAG_W-1:0]  w_iq_tag;
  logic [IQ_W-1:0]   w_iq_din;
  logic [IQ_W-1:0]   w_iq_dout;
  logic              w_iq_push;
  logic              w_iq_full;
  logic              w_iq_empty;
  logic [IQ_CW-1:0]  w_iq_count;

  logic [RQ_W-1:0]   w_rq_din;
  logic [RQ_W-1:0]   w_rq_dout;
  logic              w_rq_pop;
  logic              w_rq_full;
  logic              w_rq_empty;
  logic [RQ_CW-1:0]  w_rq_count;
  logic              w_rq_illegal;
  logic [DATA_W-1:0] w_rq_data;
  logic [TAG_W-1:0]  w_rq_tag;

  logic [RQ_CW:0]    w_inflight;
  logic              w_issue;
  logic              w_unused;

  logic              r_s1_v;
  logic [TAG_W-1:0]  r_s1_tag;
  logic              r_s1_illegal;
  logic              r_s2_v;
  logic [TAG_W-1:0]  r_s2_tag;
  logic              r_s2_illegal;

  assign w_clr = rst || flush;

  // Intake: decode on entry so the issue stage only copies fields out.
  assign in_ready  = !rst && !w_iq_full;
  assign w_iq_push = in_valid && in_ready && !flush;
  assign w_in_op   = decode_op(in_opcode, in_op1, in_op2, in_immx, in_isimm);
  assign w_iq_din  = {w_in_op, in_tag};
  assign {w_iq_op, w_iq_tag} = w_iq_dout;

  sync_fifo #(
    .WIDTH (IQ_W),
    .DEPTH (IQ_DEPTH)
  ) u_iq (
    .clk     (clk),
    .rst     (w_clr),
    .i_push  (w_iq_push),
    .i_data  (w_iq_din),
    .i_pop   (w_issue),
    .o_data  (w_iq_dout),
    .o_full  (w_iq_full),
    .o_empty (w_iq_empty),
    .o_count (w_iq_count)
  );

  // Every op in S1, S2 or the RQ already owns a result slot; a slot freed
  // by this cycle's pop may be reused by the op issued at this edge.
  assign w_rq_pop   = !w_rq_empty && res_ready;
  assign w_inflight = {1'b0, w_rq_count}
                    + (RQ_CW+1)'(r_s1_v)
                    + (RQ_CW+1)'(r_s2_v)
                    - (RQ_CW+1)'(w_rq_pop);
  assign w_issue    = !w_iq_empty && (w_inflight < (RQ_CW+1)'(RQ_DEPTH));

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      alusignals   <= '0;
      op1          <= '0;
      op2          <= '0;
      immx         <= '0;
      isimmediate  <= 1'b0;
      r_s1_v       <= 1'b0;
      r_s1_tag     <= '0;
      r_s1_illegal <= 1'b0;
      r_s2_v       <= 1'b0;
      r_s2_tag     <= '0;
      r_s2_illegal <= 1'b0;
    end else begin
      r_s1_v     <= w_issue;
      alusignals <= w_issue ? w_iq_op.ctrl : '0;
      if (w_issue) begin
        op1          <= w_iq_op.op1;
        op2          <= w_iq_op.op2;
        immx         <= w_iq_op.immx;
        isimmediate  <= w_iq_op.isimm;
        r_s1_tag     <= w_iq_tag;
        r_s1_illegal <= w_iq_op.illegal;
      end
      // S2 mirrors the ALU's own output register.
      r_s2_v       <= r_s1_v;
      r_s2_tag     <= r_s1_tag;
      r_s2_illegal <= r_s1_illegal;
    end
  end

  assign w_rq_din = {r_s2_illegal, (r_s2_illegal ? '0 : aluresult), r_s2_tag};

  sync_fifo #(
    .WIDTH (RQ_W),
    .DEPTH (RQ_DEPTH)
  ) u_rq (
    .clk     (clk),
    .rst     (w_clr),
    .i_push  (r_s2_v),
    .i_data  (w_rq_din),
    .i_pop   (w_rq_pop),
    .o_data  (w_rq_dout),
    .o_full  (w_rq_full),
    .o_empty (w_rq_empty),
    .o_count (w_rq_count)
  );

  assign {w_rq_illegal, w_rq_data, w_rq_tag} = w_rq_dout;

  assign res_valid   = !w_rq_empty;
  assign res_data    = res_valid ? w_rq_data : '0;
  assign res_tag     = res_valid ? w_rq_tag : '0;
  assign res_illegal = res_valid && w_rq_illegal;

  assign w_unused = ^{w_iq_count, w_rq_full};

endmodule

// File: tb/tb_alu_dispatch.sv
// Self-checking bench for alu_dispatch: a clocked ALU model drives aluresult,
// and an in-order queue of expected results scores every consumed result.
module tb_alu_dispatch;
  import alu_pkg::*;

  localparam int IQ_DEPTH = 4;
  localparam int RQ_DEPTH = 4;
  localparam int TAG_W    = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_opcode;
  logic [15:0]       in_op1;
  logic [15:0]       in_op2;
  logic [4:0]        in_immx;
  logic              in_isimm;
  logic [TAG_W-1:0]  in_tag;
  logic [12:0]       alusignals;
  logic [15:0]       op1;
  logic [15:0]       op2;
  logic [4:0]        immx;
  logic              isimmediate;
  logic [15:0]       aluresult;
  logic              res_valid;
  logic              res_ready;
  logic [15:0]       res_data;
  logic [TAG_W-1:0]  res_tag;
  logic              res_illegal;

  typedef struct {
    logic [15:0]      data;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   n_popped = 0;

  always #5 clk = ~clk;

  alu_dispatch #(
    .IQ_DEPTH (IQ_DEPTH),
    .RQ_DEPTH (RQ_DEPTH),
    .TAG_W    (TAG_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_opcode   (in_opcode),
    .in_op1      (in_op1),
    .in_op2      (in_op2),
    .in_immx     (in_immx),
    .in_isimm    (in_isimm),
    .in_tag      (in_tag),
    .alusignals  (alusignals),
    .op1         (op1),
    .op2         (op2),
    .immx        (immx),
    .isimmediate (isimmediate),
    .aluresult   (aluresult),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_tag     (res_tag),
    .res_illegal (res_illegal)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Arithmetic meaning of each ALU operation, indexed by opcode number.
  function automatic logic [15:0] alu_math(input int idx, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    case (idx)
      0, 1, 2: r = a + b;
      3:       r = a - b;
      4:       r = a * b;
      5:       r = a - b;
      6:       r = b;
      7:       r = a | b;
      8:       r = a & b;
      9:       r = ~a;
      10:      r = a << b[3:0];
      11:      r = a >> b[3:0];
      12:      r = $unsigned($signed(a) >>> b[3:0]);
      default: r = 16'hBAD0;
    endcase
    return r;
  endfunction

  function automatic logic [15:0] expected_result(input logic [3:0] opc, input logic [15:0] a,
                                                  input logic [15:0] b, input logic [4:0] imm,
                                                  input logic use_imm);
    if (opc > 4'd12) return 16'h0000;
    return alu_math(int'(opc), a, use_imm ? {11'b0, imm} : b);
  endfunction

  // External clocked ALU: any control word that is not one-hot yields a
  // poison value, so a wrongly issued or unforced illegal op is visible.
  always @(posedge clk) begin
    int idx;
    idx = -1;
    if ($onehot(alusignals)) begin
      for (int k = 0; k < 13; k++) if (alusignals[k]) idx = k;
    end
    aluresult <= alu_math(idx, op1, isimmediate ? {11'b0, immx} : op2);
  end

  // Scoreboard: expectations enter at acceptance and leave at consumption.
  always @(negedge clk) begin
    exp_t e;
    if (rst || flush) begin
      exp_q.delete();
    end else begin
      if (res_valid && res_ready) begin
        n_popped++;
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'(res_valid), 32'h0);
        end else begin
          e = exp_q.pop_front();
          check("sb_tag", 32'(res_tag), 32'(e.tag));
          check("sb_data", 32'(res_data), 32'(e.data));
          check("sb_illegal", 32'(res_illegal), 32'(e.illegal));
        end
      end
      if (in_valid && in_ready) begin
        e.data    = expected_result(in_opcode, in_op1, in_op2, in_immx, in_isimm);
        e.tag     = in_tag;
        e.illegal = (in_opcode > 4'd12);
        exp_q.push_back(e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [3:0] opc, input logic [15:0] a, input logic [15:0] b,
                        input logic [4:0] imm, input logic use_imm, input logic [TAG_W-1:0] tag);
    in_opcode = opc;
    in_op1    = a;
    in_op2    = b;
    in_immx   = imm;
    in_isimm  = use_imm;
    in_tag    = tag;
  endtask

  task automatic set_rnd_op(input logic [TAG_W-1:0] tag);
    set_op(4'($urandom_range(0, 12)), 16'($urandom), 16'($urandom),
           5'($urandom), 1'($urandom), tag);
  endtask

  task automatic drain(input int budget);
    for (int k = 0; k < budget && exp_q.size() != 0; k++) tick();
    tick();
    tick();
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_in_ready"}, 32'(in_ready), 32'h0);
    check({pfx, "_alusignals"}, 32'(alusignals), 32'h0);
    check({pfx, "_op1"}, 32'(op1), 32'h0);
    check({pfx, "_op2"}, 32'(op2), 32'h0);
    check({pfx, "_immx_isimm"}, 32'({immx, isimmediate}), 32'h0);
    check({pfx, "_res_valid"}, 32'(res_valid), 32'h0);
    check({pfx, "_res_fields"}, 32'({res_data, res_tag, res_illegal}), 32'h0);
  endtask

  initial begin
    int acc;
    int popped_before;

    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    res_ready = 1'b1;
    set_op(4'd0, 16'h0, 16'h0, 5'h0, 1'b0, '0);
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    #1;
    check("reset_release_in_ready", 32'(in_ready), 32'h1);
    tick();

    // Single ADD: latency and one-cycle control pulse.
    set_op(OP_ADD, 16'h0005, 16'h0003, 5'h0, 1'b0, 4'd3);
    in_valid = 1'b1;
    check("add_in_ready", 32'(in_ready), 32'h1);
    tick();
    in_valid = 1'b0;
    check("add_no_bypass", 32'(alusignals), 32'h0);
    tick();
    check("add_ctrl", 32'(alusignals), 32'h0001);
    check("add_operands", {op1, op2}, 32'h0005_0003);
    tick();
    check("add_ctrl_pulse", 32'(alusignals), 32'h0);
    check("add_not_early", 32'(res_valid), 32'h0);
    tick();
    check("add_res_valid", 32'(res_valid), 32'h1);
    check("add_res_data", 32'(res_data), 32'h0008);
    check("add_res_tag", 32'(res_tag), 32'h3);
    tick();
    check("add_res_gone", 32'(res_valid), 32'h0);

    // Back-to-back stream of 10 ops with the consumer always ready.
    for (int i = 0; i < 10; i++) begin
      check("stream_res_valid", 32'(res_valid), 32'(i - 1 >= 3));
      set_rnd_op(TAG_W'(i));
      in_valid = 1'b1;
      check("stream_in_ready", 32'(in_ready), 32'h1);
      tick();
    end
    in_valid = 1'b0;
    for (int k = 9; k < 14; k++) begin
      check("stream_tail_valid", 32'(res_valid), 32'(k <= 12));
      tick();
    end
    check("stream_drained", 32'(exp_q.size()), 32'h0);

    // Consumer stalled: exactly IQ_DEPTH + RQ_DEPTH ops fit.
    res_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 20; c++) begin
      set_rnd_op(TAG_W'(c));
      in_valid = 1'b1;
      if (in_ready) acc++;
      tick();
    end
    check("bp_accepted", 32'(acc), 32'(IQ_DEPTH + RQ_DEPTH));
    check("bp_in_ready_low", 32'(in_ready), 32'h0);
    in_valid      = 1'b0;
    popped_before = n_popped;
    res_ready     = 1'b1;
    drain(40);
    check("bp_results", 32'(n_popped - popped_before), 32'(IQ_DEPTH + RQ_DEPTH));
    check("bp_drained", 32'(exp_q.size()), 32'h0);

    // Illegal opcode still flows through as a zero-data result.
    set_op(4'd14, 16'h1234, 16'h4321, 5'h0, 1'b0, 4'd7);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("illegal_ctrl", 32'(alusignals), 32'h0);
    check("illegal_issued", 32'(op1), 32'h1234);
    tick();
    tick();
    check("illegal_res_valid", 32'(res_valid), 32'h1);
    check("illegal_flag", 32'(res_illegal), 32'h1);
    check("illegal_data", 32'(res_data), 32'h0);
    check("illegal_tag", 32'(res_tag), 32'h7);
    tick();

    // Flush with ops waiting in the IQ and one in the ALU stage.
    res_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      set_rnd_op(TAG_W'(c));
      in_valid = 1'b1;
      tick();
    end
    check("preflush_res_valid", 32'(res_valid), 32'h1);
    set_op(OP_ADD, 16'h0001, 16'h0001, 5'h0, 1'b0, 4'd15);
    flush = 1'b1;
    tick();
    flush     = 1'b0;
    in_valid  = 1'b0;
    res_ready = 1'b1;
    check("flush_res_valid", 32'(res_valid), 32'h0);
    check("flush_ctrl", 32'(alusignals), 32'h0);
    check("flush_in_ready", 32'(in_ready), 32'h1);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("flush_no_stale", 32'(res_valid), 32'h0);
    end
    set_op(OP_SUB, 16'h0005, 16'h0003, 5'h0, 1'b0, 4'd9);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    check("postflush_valid", 32'(res_valid), 32'h1);
    check("postflush_sub", 32'(res_data), 32'h0002);
    tick();

    // Reset in the middle of a stream.
    for (int c = 0; c < 3; c++) begin
      set_rnd_op(TAG_W'(c));
      in_valid = 1'b1;
      tick();
    end
    rst = 1'b1;
    tick();
    check_reset_outputs("midrst");
    tick();
    check("midrst_hold_in_ready", 32'(in_ready), 32'h0);
    rst      = 1'b0;
    in_valid = 1'b0;
    tick();
    tick();
    check("postrst_quiet", 32'(res_valid), 32'h0);
    set_op(OP_MOV, 16'($urandom), 16'($urandom), 5'd3, 1'b1, 4'd5);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    check("postrst_valid", 32'(res_valid), 32'h1);
    check("postrst_mov", 32'(res_data), 32'h0003);
    check("postrst_tag", 32'(res_tag), 32'h5);
    tick();

    // Random traffic, stalls and occasional flushes against the scoreboard.
    for (int c = 0; c < 400; c++) begin
      set_op(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom),
             5'($urandom), 1'($urandom), TAG_W'($urandom));
      in_valid  = ($urandom_range(0, 3) != 0);
      res_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 99) == 0);
      tick();
    end
    flush     = 1'b0;
    in_valid  = 1'b0;
    res_ready = 1'b1;
    drain(50);
    check("random_drained", 32'(exp_q.size()), 32'h0);
    check("random_final_empty", 32'(res_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_dispatch.md
Name: alu_dispatch

Overview:
Upstream driver and result collector for the clocked ALU. It accepts decoded ALU operations over a valid/ready handshake and buffers them in an instruction FIFO. It drives the ALU's alusignals/op1/op2/immx/isimmediate inputs from registers, then captures the registered aluresult into a tagged result queue, with credit-based flow control so no ALU result is ever dropped.

Parameters:
IQ_DEPTH, 4, instruction FIFO entries (power of 2, ≥2)
RQ_DEPTH, 4, result queue entries (power of 2, ≥2)
TAG_W, 4, width of destination tag carried with each op

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset
flush  in  1  synchronous discard of all queued/in-flight ops
in_valid  in  1  op offered
in_ready  out  1  FIFO can accept (= !iq_full)
in_opcode  in  4  ALU op index 0..15
in_op1  in  16  operand 1
in_op2  in  16  operand 2
in_immx  in  5  immediate
in_isimm  in  1  use immediate for operand 2
in_tag  in  TAG_W  destination tag
alusignals  out  13  one-hot ALU control, registered
op1  out  16  to ALU, registered
op2  out  16  to ALU, registered
immx  out  5  to ALU, registered
isimmediate  out  1  to ALU, registered
aluresult  in  16  registered ALU output
res_valid  out  1  result queue non-empty
res_ready  in  1  consumer accepts head
res_data  out  16  result
res_tag  out  TAG_W  tag of result
res_illegal  out  1  op had undefined opcode

Behaviour:
- Reset (rst high at edge): IQ, pipe, and RQ are emptied. alusignals=0, op1=op2=0, immx=0, isimmediate=0. res_valid=0, res_data=0, res_tag=0, res_illegal=0. in_ready reads 1 from the first cycle after reset; it is held 0 while rst is high.
- Opcode decode: alusignals = 1<<in_opcode for opcodes 0..12.
  - Bit map: 0 add, 1 ld, 2 st, 3 sub, 4 mul, 5 cmp, 6 mov, 7 or, 8 and, 9 not, 10 lsl, 11 lsr, 12 asr.
  - Opcodes 13..15 are illegal: alusignals=0, illegal flag carried with the op.
- Accept: an op is accepted on the edge where in_valid && in_ready. in_valid while in_ready=0 is held off, with no effect.
- Issue stage (S1):
  - Registered outputs load from the IQ head, popping it, when IQ is non-empty and credits are available.
  - Credits are available when s1_v + s2_v + rq_count − (res_valid && res_ready) < RQ_DEPTH.
  - When no issue occurs, alusignals is forced to 0. op1/op2/immx/isimmediate hold their last values.
- ALU stage (S2): tag, illegal flag and valid move S1→S2 on every edge, matching the ALU's one-cycle register.
- Capture: on the edge after S2 is valid, aluresult is pushed into the RQ with its tag. For illegal ops, res_data is forced to 0.
- Latency: op accepted at edge E0 → S1 loaded E1 → ALU result E2 → RQ push E3.
  - res_valid=1 during the cycle after E3 with an empty pipe: 3 cycles from accept.
  - Throughput is 1 op/cycle while res_ready=1.
- Ordering: results leave strictly in acceptance order.
- Simultaneous events:
  - IQ push and pop in the same cycle when full: push is allowed only if in_ready was 1, i.e. no same-cycle full bypass.
  - IQ empty→S1 bypass is not provided; minimum 1 cycle in the IQ.
  - RQ push and pop in the same cycle keeps the count.
- RQ full: the credit check guarantees S2 never captures into a full RQ. A full RQ is an assertion failure in verification.
- Back-pressure: res_ready=0 for long periods leaves IQ filling and in_ready=0 at IQ_DEPTH ops. No data is lost.
- flush (rst has priority over flush): same clearing as reset except in_ready stays 1. alusignals=0 at the next edge. An ALU result already in flight is discarded, not pushed. Inputs offered in the flush cycle are dropped.
- Pointer wrap: IQ and RQ pointers carry an extra MSB for full/empty and wrap modulo 2·depth.

Decomposition:
- Shared package alu_pkg:
  - ALU opcode constants (OP_ADD=0 … OP_ASR=12).
  - alusignals bit indices.
  - ALU_CTRL_W=13, DATA_W=16, IMM_W=5.
- One sub-module: sync_fifo (parameterised width/depth, synchronous reset, push/pop/full/empty/count). Instantiated twice, as IQ and RQ.

Test Plan:
- Single ADD: opcode 0, op1=0x0005, op2=0x0003, isimm=0, tag=3. alusignals=0x0001 for exactly one cycle; res_valid 3 cycles after accept; res_data=0x0008, res_tag=3.
- Stream of 10 ops with res_ready=1 and in_valid held high. One result per cycle after the initial 3-cycle latency; tags emerge in order 0..9; in_ready never drops.
- res_ready=0 with continuous input. Exactly RQ_DEPTH+IQ_DEPTH ops are accepted (8 at defaults) and in_ready falls to 0. After releasing res_ready, all 8 results appear in order with none lost.
- Illegal opcode 14, tag=7. alusignals stays 0x0000 for the op's issue cycle; the result has res_illegal=1, res_data=0x0000, tag 7.
- Flush with 2 ops in the IQ and 1 in S2. The next cycle has res_valid=0 and alusignals=0. No stale result appears over the next 5 cycles. A new SUB 5−3 then returns 0x0002.
- rst asserted mid-stream. All outputs take their reset values at the edge and in_ready=0 while rst is high. After deassertion the first accepted MOV immx=3, isimm=1 returns 0x0003.
